// File: rtl/afc_pkg.sv
// Shared definitions for the AFC band-search controller: comparator codes,
// FSM state encoding and saturation flag bit positions.
package afc_pkg;

  localparam logic [2:0] COMP_FAST   = 3'b100;
  localparam logic [2:0] COMP_SLOW   = 3'b010;
  localparam logic [2:0] COMP_FREEZE = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_FAIL
  } afc_state_e;

  localparam int SAT_HI = 1;
  localparam int SAT_LO = 0;

endpackage

// File: rtl/afc_step_calc.sv
// One binary-search step: next low/high/band for a SLOW or FAST verdict, plus
// range-edge flags. Arithmetic is one bit wider than the band so nothing wraps.
module afc_step_calc #(
  parameter int BAND_W = 5
) (
  input  logic [BAND_W-1:0] band_i,
  input  logic [BAND_W-1:0] low_i,
  input  logic [BAND_W-1:0] high_i,
  input  logic              slow_i,
  input  logic              fast_i,
  output logic [BAND_W-1:0] low_o,
  output logic [BAND_W-1:0] high_o,
  output logic [BAND_W-1:0] band_o,
  output logic              sat_hi_o,
  output logic              sat_lo_o
);

  localparam logic [BAND_W:0] ONE = (BAND_W+1)'(1);

  logic [BAND_W:0] band_p1;
  logic [BAND_W:0] band_m1;
  logic [BAND_W:0] sum_up;
  logic [BAND_W:0] sum_dn;
  logic            unused_bits;

  assign band_p1  = {1'b0, band_i} + ONE;
  assign band_m1  = {1'b0, band_i} - ONE;
  assign sum_up   = band_p1 + {1'b0, high_i};
  assign sum_dn   = {1'b0, low_i} + band_m1;
  assign sat_hi_o = (band_i == high_i);
  assign sat_lo_o = (band_i == low_i);

  // The carry of band+/-1 and the LSB of the halved sums are never needed.
  assign unused_bits = ^{band_p1[BAND_W], band_m1[BAND_W], sum_up[0], sum_dn[0]};

  always_comb begin
    low_o  = low_i;
    high_o = high_i;
    band_o = band_i;
    if (slow_i && !sat_hi_o) begin
      low_o  = band_p1[BAND_W-1:0];
      band_o = sum_up[BAND_W:1];
    end else if (fast_i && !sat_lo_o) begin
      high_o = band_m1[BAND_W-1:0];
      band_o = sum_dn[BAND_W:1];
    end
  end

endmodule

// File: rtl/afc_search_ctrl.sv
// AFC binary band search: drives the VCO band, handshakes with the frequency
// comparator (change/done), retries on timeout or garbled verdicts.
//
// state | meaning
// IDLE  | parked on INIT_BAND, waiting for start (or auto start after reset)
// REQ   | one-cycle change pulse, band is stable
// WAIT  | waiting for done; timeout down-counter running
// DONE  | locked or saturated at a range edge; finish held
// FAIL  | retries exhausted; fail held
module afc_search_ctrl
  import afc_pkg::*;
#(
  parameter int BAND_W      = 5,
  parameter int BAND_LO     = 0,
  parameter int BAND_HI     = 2**BAND_W - 1,
  parameter int INIT_BAND   = 2**(BAND_W-1),
  parameter int TIMEOUT_CYC = 64,
  parameter int MAX_RETRY   = 3,
  parameter int AUTO_START  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        comp_in,
  input  logic              done,
  output logic              change,
  output logic [BAND_W-1:0] band,
  output logic              busy,
  output logic              finish,
  output logic              fail,
  output logic [1:0]        sat,
  output logic [BAND_W:0]   iter_cnt
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [RTY_W-1:0]  RTY_ONE  = RTY_W'(1);
  localparam logic [BAND_W-1:0] LO_B     = BAND_W'(BAND_LO);
  localparam logic [BAND_W-1:0] HI_B     = BAND_W'(BAND_HI);
  localparam logic [BAND_W-1:0] INIT_B   = BAND_W'(INIT_BAND);
  localparam logic [BAND_W:0]   ITER_ONE = (BAND_W+1)'(1);
  localparam logic              AUTO_EN  = (AUTO_START != 0);

  afc_state_e        state_q, state_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic [BAND_W-1:0] low_q, low_d;
  logic [BAND_W-1:0] high_q, high_d;
  logic [1:0]        sat_q, sat_d;
  logic [BAND_W:0]   iter_q, iter_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [RTY_W-1:0]  rty_q, rty_d;
  logic              first_q;
  logic              change_q, busy_q, finish_q, fail_q;

  logic [BAND_W-1:0] step_low, step_high, step_band;
  logic              sat_hi, sat_lo;
  logic              verdict_ok;
  logic              retry_req;

  afc_step_calc #(.BAND_W(BAND_W)) u_step (
    .band_i   (band_q),
    .low_i    (low_q),
    .high_i   (high_q),
    .slow_i   (comp_in == COMP_SLOW),
    .fast_i   (comp_in == COMP_FAST),
    .low_o    (step_low),
    .high_o   (step_high),
    .band_o   (step_band),
    .sat_hi_o (sat_hi),
    .sat_lo_o (sat_lo)
  );

  assign verdict_ok = (comp_in == COMP_FAST) || (comp_in == COMP_SLOW) ||
                      (comp_in == COMP_FREEZE);

  always_comb begin
    state_d   = state_q;
    band_d    = band_q;
    low_d     = low_q;
    high_d    = high_q;
    sat_d     = sat_q;
    iter_d    = iter_q;
    tmo_d     = tmo_q;
    rty_d     = rty_q;
    retry_req = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start || (state_q == ST_IDLE && AUTO_EN && first_q)) begin
          state_d = ST_REQ;
          low_d   = LO_B;
          high_d  = HI_B;
          band_d  = INIT_B;
          sat_d   = '0;
          iter_d  = '0;
          rty_d   = '0;
        end
      end
      ST_REQ: begin
        tmo_d   = TMO_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over an expiring timeout in the same cycle
        if (done) begin
          if (verdict_ok) begin
            iter_d = iter_q + ITER_ONE;
            rty_d  = '0;
            if (comp_in == COMP_FREEZE) begin
              state_d = ST_DONE;
              sat_d   = '0;
            end else if (comp_in == COMP_SLOW && sat_hi) begin
              state_d        = ST_DONE;
              sat_d          = '0;
              sat_d[SAT_HI]  = 1'b1;
            end else if (comp_in == COMP_FAST && sat_lo) begin
              state_d        = ST_DONE;
              sat_d          = '0;
              sat_d[SAT_LO]  = 1'b1;
            end else begin
              low_d   = step_low;
              high_d  = step_high;
              band_d  = step_band;
              state_d = ST_REQ;
            end
          end else begin
            retry_req = 1'b1;
          end
        end else if (tmo_q == '0) begin
          retry_req = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (retry_req) begin
      if (rty_q == RTY_MAX) begin
        state_d = ST_FAIL;
      end else begin
        rty_d   = rty_q + RTY_ONE;
        state_d = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      band_q   <= INIT_B;
      low_q    <= LO_B;
      high_q   <= HI_B;
      sat_q    <= '0;
      iter_q   <= '0;
      tmo_q    <= '0;
      rty_q    <= '0;
      first_q  <= 1'b1;
      change_q <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      band_q   <= band_d;
      low_q    <= low_d;
      high_q   <= high_d;
      sat_q    <= sat_d;
      iter_q   <= iter_d;
      tmo_q    <= tmo_d;
      rty_q    <= rty_d;
      first_q  <= 1'b0;
      change_q <= (state_d == ST_REQ);
      busy_q   <= (state_d == ST_REQ) || (state_d == ST_WAIT);
      finish_q <= (state_d == ST_DONE);
      fail_q   <= (state_d == ST_FAIL);
    end
  end

  assign change   = change_q;
  assign band     = band_q;
  assign busy     = busy_q;
  assign finish   = finish_q;
  assign fail     = fail_q;
  assign sat      = sat_q;
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_afc_search_ctrl.sv
// Directed bench for afc_search_ctrl: three instances (default, narrowed range,
// short timeout) driven from a step table plus hand-written corner sequences.
module tb_afc_search_ctrl;
  import afc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_s  [3];
  logic [2:0] comp_s   [3];
  logic       done_s   [3];
  logic       change_s [3];
  logic [4:0] band_s   [3];
  logic       busy_s   [3];
  logic       finish_s [3];
  logic       fail_s   [3];
  logic [1:0] sat_s    [3];
  logic [5:0] iter_s   [3];

  int total = 0;
  int bad   = 0;

  afc_search_ctrl u_d0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .comp_in(comp_s[0]), .done(done_s[0]),
    .change(change_s[0]), .band(band_s[0]), .busy(busy_s[0]), .finish(finish_s[0]),
    .fail(fail_s[0]), .sat(sat_s[0]), .iter_cnt(iter_s[0]));

  afc_search_ctrl #(.BAND_LO(4), .BAND_HI(11), .INIT_BAND(8)) u_d1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .comp_in(comp_s[1]), .done(done_s[1]),
    .change(change_s[1]), .band(band_s[1]), .busy(busy_s[1]), .finish(finish_s[1]),
    .fail(fail_s[1]), .sat(sat_s[1]), .iter_cnt(iter_s[1]));

  afc_search_ctrl #(.TIMEOUT_CYC(8), .MAX_RETRY(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .comp_in(comp_s[2]), .done(done_s[2]),
    .change(change_s[2]), .band(band_s[2]), .busy(busy_s[2]), .finish(finish_s[2]),
    .fail(fail_s[2]), .sat(sat_s[2]), .iter_cnt(iter_s[2]));

  typedef struct {
    int         k;         // instance
    int         pre;       // 0 none, 1 reset, 2 start pulse
    logic [2:0] code;      // verdict returned for this request
    logic [4:0] exp_band;  // band during the change pulse
    logic [5:0] exp_iter;  // iter_cnt during the change pulse
    bit         last;      // search should end after this verdict
    logic [1:0] end_sat;
    logic [4:0] end_band;
    logic [5:0] end_iter;
  } step_t;

  step_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    @(posedge clk); #1;
    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
  endtask

  task automatic wait_change(input int k, output bit ok);
    ok = change_s[k];
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      ok = change_s[k];
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL change_wait: no change pulse on instance %0d (t=%0t)", k, $time);
    end
  endtask

  task automatic respond(input int k, input logic [2:0] code);
    @(posedge clk); #1;
    done_s[k] = 1'b1;
    comp_s[k] = code;
    @(posedge clk); #1;
    done_s[k] = 1'b0;
    comp_s[k] = 3'b000;
  endtask

  initial begin
    bit ok;
    int pos[$];
    int exp_pos[3];
    logic [4:0] rst_band[3];

    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      comp_s[k]  = 3'b000;
      done_s[k]  = 1'b0;
    end
    exp_pos  = '{1, 10, 19};
    rst_band = '{5'd16, 5'd8, 5'd16};

    //            k pre code         band it last sat    band  iter
    tbl.push_back('{0, 1, COMP_SLOW,   16, 0, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_SLOW,   24, 1, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_FREEZE, 28, 2, 1, 2'b00, 28, 3});
    tbl.push_back('{0, 2, COMP_FAST,   16, 0, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_FAST,    7, 1, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_FAST,    3, 2, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_FAST,    1, 3, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_FAST,    0, 4, 1, 2'b01,  0, 5});
    tbl.push_back('{1, 1, COMP_SLOW,    8, 0, 0, 2'b00,  0, 0});
    tbl.push_back('{1, 0, COMP_SLOW,   10, 1, 0, 2'b00,  0, 0});
    tbl.push_back('{1, 0, COMP_SLOW,   11, 2, 1, 2'b10, 11, 3});
    tbl.push_back('{0, 1, 3'b110,      16, 0, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_SLOW,   16, 0, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_FREEZE, 24, 1, 1, 2'b00, 24, 2});
    tbl.push_back('{0, 1, 3'b000,      16, 0, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_FAST,   16, 0, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_SLOW,    7, 1, 0, 2'b00,  0, 0});
    tbl.push_back('{0, 0, COMP_FREEZE, 11, 2, 1, 2'b00, 11, 3});

    // Reset state of every instance
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_band",   band_s[k],   rst_band[k]);
      chk("rst_change", change_s[k], 0);
      chk("rst_busy",   busy_s[k],   0);
      chk("rst_finish", finish_s[k], 0);
      chk("rst_fail",   fail_s[k],   0);
      chk("rst_sat",    sat_s[k],    0);
      chk("rst_iter",   iter_s[k],   0);
    end

    // Table-driven searches
    foreach (tbl[i]) begin
      if (tbl[i].pre == 1) do_reset();
      else if (tbl[i].pre == 2) pulse_start(tbl[i].k);
      wait_change(tbl[i].k, ok);
      if (ok) begin
        chk($sformatf("step%0d_band", i),   band_s[tbl[i].k],   tbl[i].exp_band);
        chk($sformatf("step%0d_iter", i),   iter_s[tbl[i].k],   tbl[i].exp_iter);
        chk($sformatf("step%0d_busy", i),   busy_s[tbl[i].k],   1);
        chk($sformatf("step%0d_finish", i), finish_s[tbl[i].k], 0);
        chk($sformatf("step%0d_fail", i),   fail_s[tbl[i].k],   0);
        respond(tbl[i].k, tbl[i].code);
        if (tbl[i].last) begin
          repeat (3) @(posedge clk);
          #1;
          chk($sformatf("step%0d_end_finish", i), finish_s[tbl[i].k], 1);
          chk($sformatf("step%0d_end_sat", i),    sat_s[tbl[i].k],    tbl[i].end_sat);
          chk($sformatf("step%0d_end_band", i),   band_s[tbl[i].k],   tbl[i].end_band);
          chk($sformatf("step%0d_end_iter", i),   iter_s[tbl[i].k],   tbl[i].end_iter);
          chk($sformatf("step%0d_end_busy", i),   busy_s[tbl[i].k],   0);
          chk($sformatf("step%0d_end_fail", i),   fail_s[tbl[i].k],   0);
        end
      end
    end

    // Timeout / retry exhaustion on the short-timeout instance
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (change_s[2]) pos.push_back(n);
      if (n == 27) chk("tmo_fail_early", fail_s[2], 0);
      if (n == 28) chk("tmo_fail_set",   fail_s[2], 1);
    end
    chk("tmo_pulse_count", pos.size(), 3);
    for (int i = 0; i < 3 && i < pos.size(); i++)
      chk($sformatf("tmo_pulse%0d_cycle", i), pos[i], exp_pos[i]);
    chk("tmo_band",   band_s[2],   16);
    chk("tmo_busy",   busy_s[2],   0);
    chk("tmo_finish", finish_s[2], 0);
    chk("tmo_iter",   iter_s[2],   0);

    // Start ignored while busy, then async reset in WAIT, then restart
    do_reset();
    wait_change(0, ok);
    respond(0, COMP_SLOW);
    wait_change(0, ok);
    chk("mid_band_before", band_s[0], 24);
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    chk("busy_start_change", change_s[0], 0);
    chk("busy_start_busy",   busy_s[0],   1);
    chk("busy_start_band",   band_s[0],   24);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_band", band_s[0], 16);
    chk("async_rst_busy", busy_s[0], 0);
    chk("async_rst_iter", iter_s[0], 0);
    @(negedge clk);
    rst = 1'b0;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_change(0, ok);
    chk("restart_band",   band_s[0],   16);
    chk("restart_finish", finish_s[0], 0);
    chk("restart_fail",   fail_s[0],   0);
    chk("restart_busy",   busy_s[0],   1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afc_search_ctrl.md
Name: afc_search_ctrl

Overview:
Parametrised automatic-frequency-calibration band-search controller. It drives the VCO band select and runs a binary search over a configurable band range, using the FAST/SLOW/FREEZE verdicts from the frequency comparator. Compared with the fixed 5-bit search, it adds a configurable band width, range and start band, explicit start/restart, comparator-response timeout with retry, saturation detection at the range edges, and an iteration counter. It sits between the frequency comparator (change/done handshake) and the VCO capacitor-bank decoder.

Parameters:
BAND_W, 5, band select width; bands 0..2^BAND_W-1
BAND_LO, 0, lowest searchable band
BAND_HI, 2^BAND_W-1, highest searchable band
INIT_BAND, 2^(BAND_W-1), band driven in IDLE and at reset
TIMEOUT_CYC, 64, cycles in WAIT without done before a retry
MAX_RETRY, 3, retries of one band before fail
AUTO_START, 1, 1 = search starts on the first cycle after reset release without a start pulse

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; starts a search from IDLE/DONE/FAIL; ignored while busy
comp_in  in  3  comparator verdict: FAST=3'b100 (lower band), SLOW=3'b010 (raise band), FREEZE=3'b001 (lock)
done  in  1  comparator result valid; comp_in sampled only with done=1
change  out  1  one-cycle pulse: band is stable, start comparison
band  out  BAND_W  current band select
busy  out  1  search in progress (REQ or WAIT)
finish  out  1  search ended with lock or saturation; held until next start
fail  out  1  search aborted by timeout; held until next start
sat  out  2  [1]=saturated high, [0]=saturated low; valid while finish=1
iter_cnt  out  BAND_W+1  comparisons completed in the current search

Behaviour:
- Reset (async, while rst=1): state=IDLE, low=BAND_LO, high=BAND_HI, band=INIT_BAND; change, busy, finish, fail, sat and iter_cnt all 0; retry and timeout counters cleared. Reset mid-search abandons the search immediately.
- States: IDLE, REQ, WAIT, DONE, FAIL. All outputs are registered.
- IDLE -> REQ: on start, or on the first cycle after reset release when AUTO_START=1. On entry: low/high are reloaded, band=INIT_BAND, and finish/fail/sat/iter_cnt are cleared.
- REQ: change=1 for exactly this one cycle, then -> WAIT. The timeout counter clears.
- WAIT: done is ignored in the cycle change is high. When done=1, comp_in is sampled and the result takes effect at that edge:
  - FREEZE -> DONE; band is held; sat=00.
  - SLOW:
    - band==high -> DONE with sat=10.
    - otherwise low=band+1 and band=(band+1+high)>>1, then -> REQ.
  - FAST:
    - band==low -> DONE with sat=01.
    - otherwise high=band-1 and band=(low+band-1)>>1, then -> REQ.
  - Any other comp_in code (including 000 and multi-hot): treated as a missed response and counts as one retry.
  - iter_cnt increments on every legal verdict.
- Arithmetic: sums and differences are computed at BAND_W+1 bits, so nothing wraps. The guards above mean low never exceeds high.
- Timeout: if TIMEOUT_CYC cycles pass in WAIT with no done, retry: -> REQ on the same band and increment the retry counter. The retry counter clears on any legal verdict. A retry request that would exceed MAX_RETRY goes -> FAIL instead.
- DONE: finish=1, busy=0, band held. FAIL: fail=1, busy=0, band held. Both leave only on start (-> REQ) or reset.
- busy=1 in REQ and WAIT. start while busy has no effect.
- Simultaneous done and timeout-expiry in WAIT: done wins.
- Latency: the change pulse is asserted in the cycle after the edge that sampled done.

Decomposition:
- Package afc_pkg: comparator code constants FAST/SLOW/FREEZE, the state enum, and the sat bit indices.
- One sub-module, afc_step_calc: combinational next-low/high/band calculator plus saturation flags, parametrised by BAND_W. This lets it be unit-tested in isolation.

Test Plan:
- Defaults, AUTO_START=1; respond done with SLOW, SLOW, FREEZE -> band sequence 16 -> 24 -> 28, finish=1, band=28, sat=00, iter_cnt=3.
- Respond FAST five times -> band 16 -> 7 -> 3 -> 1 -> 0; the fifth FAST at band 0 gives finish=1, sat=01, band=0.
- BAND_LO=4, BAND_HI=11, INIT_BAND=8; SLOW repeatedly -> band 8 -> 10 -> 11, then SLOW at 11 gives sat=10, finish=1.
- TIMEOUT_CYC=8, MAX_RETRY=2, done never asserted -> change pulses at cycles 1, 10, 19, then fail=1 with band still 16.
- comp_in=3'b110 with done, then SLOW -> the first counts as a retry with band unchanged; then band=24 and iter_cnt=1.
- Assert rst in WAIT at band 24, release, then send start -> band=16, fail/finish=0, and a new change pulse follows.
